// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencing logic: FSM state
// encoding, the default WAIT-state timeout and the cycle counter width.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_START = 2'b01,
        MD_WAIT  = 2'b10,
        MD_DONE  = 2'b11
    } md_state_e;

    // WAIT-state cycles allowed before the sequencer gives up on the unit.
    localparam int MD_MAX_CYCLES_DEFAULT = 40;

    // Width of the WAIT-state cycle counter; holds any legal timeout (2..63).
    localparam int MD_CNT_W = 6;

endpackage

// File: rtl/multdiv_sequencer_cycle_counter.sv
// Six-bit cycle counter with synchronous clear and count enable. The
// terminal output flags the last WAIT cycle that may pass before timeout.
module md_cycle_counter
    import multdiv_sequencer_pkg::*;
#(
    parameter logic [MD_CNT_W-1:0] TERMINAL = 6'd39
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [MD_CNT_W-1:0] count_r;

    // Count register: reset and clear force zero, enable advances by one.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 6'd0;
        end else if (clear) begin
            count_r <= 6'd0;
        end else if (enable) begin
            count_r <= count_r + 6'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == TERMINAL);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequencer that hands a DX-stage mult/div to the multi-cycle multdiv unit,
// stalls the front of the pipeline while the unit works, and delivers a
// single result strobe (or a timeout error) to the XM latch.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int MAX_CYCLES = MD_MAX_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall,
    output logic        nop_insert,
    output logic        done,
    output logic [31:0] result,
    output logic        exception,
    output logic        busy
);

    // Counter value seen on the last WAIT cycle before the timeout fires.
    localparam logic [MD_CNT_W-1:0] TERMINAL_C = MD_CNT_W'(MAX_CYCLES - 1);

    md_state_e   state_r;
    md_state_e   state_next_s;
    logic        req_s;
    logic        capture_ops_s;
    logic        op_mult_r;
    logic        op_mult_next_s;
    logic        cnt_clear_s;
    logic        cnt_enable_s;
    logic        cnt_terminal_s;
    logic        cap_unit_s;
    logic        cap_timeout_s;
    logic        ctrl_mult_r;
    logic        ctrl_div_r;
    logic        done_r;
    logic        busy_r;
    logic [31:0] md_a_r;
    logic [31:0] md_b_r;
    logic [31:0] result_r;
    logic        exception_r;

    assign req_s = is_mult | is_div;

    md_cycle_counter #(
        .TERMINAL (TERMINAL_C)
    ) u_cycle_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .enable   (cnt_enable_s),
        .terminal (cnt_terminal_s)
    );

    // Next-state logic; a request is only looked at while IDLE, so the
    // instruction still sitting in DX during DONE cannot retrigger.
    always_comb begin
        state_next_s  = state_r;
        capture_ops_s = 1'b0;
        cnt_clear_s   = 1'b0;
        cnt_enable_s  = 1'b0;
        cap_unit_s    = 1'b0;
        cap_timeout_s = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (req_s) begin
                    capture_ops_s = 1'b1;
                    state_next_s  = MD_START;
                end else begin
                    state_next_s  = MD_IDLE;
                end
            end
            MD_START: begin
                cnt_clear_s  = 1'b1;
                state_next_s = MD_WAIT;
            end
            MD_WAIT: begin
                if (md_ready) begin
                    // A ready unit beats a coincident timeout.
                    cap_unit_s   = 1'b1;
                    state_next_s = MD_DONE;
                end else begin
                    cnt_enable_s = 1'b1;
                    if (cnt_terminal_s) begin
                        cap_timeout_s = 1'b1;
                        state_next_s  = MD_DONE;
                    end else begin
                        state_next_s  = MD_WAIT;
                    end
                end
            end
            MD_DONE: begin
                state_next_s = MD_IDLE;
            end
            default: begin
                state_next_s = MD_IDLE;
            end
        endcase
    end

    // Op type for the upcoming START; mult wins when both requests are high.
    always_comb begin
        op_mult_next_s = op_mult_r;
        if (capture_ops_s) begin
            op_mult_next_s = is_mult;
        end else begin
            op_mult_next_s = op_mult_r;
        end
    end

    // State register and op-type latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= MD_IDLE;
            op_mult_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            op_mult_r <= op_mult_next_s;
        end
    end

    // Control outputs registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_mult_r <= 1'b0;
            ctrl_div_r  <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ctrl_mult_r <= (state_next_s == MD_START) & op_mult_next_s;
            ctrl_div_r  <= (state_next_s == MD_START) & ~op_mult_next_s;
            done_r      <= (state_next_s == MD_DONE);
            busy_r      <= (state_next_s == MD_START) | (state_next_s == MD_WAIT);
        end
    end

    // Operand hold registers; loaded only on acceptance, stable until the next.
    always_ff @(posedge clock) begin
        if (reset) begin
            md_a_r <= 32'd0;
            md_b_r <= 32'd0;
        end else if (capture_ops_s) begin
            md_a_r <= op_a;
            md_b_r <= op_b;
        end else begin
            md_a_r <= md_a_r;
            md_b_r <= md_b_r;
        end
    end

    // Result capture: unit values on ready, zero plus error on timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_r    <= 32'd0;
            exception_r <= 1'b0;
        end else if (cap_unit_s) begin
            result_r    <= md_result;
            exception_r <= md_exception;
        end else if (cap_timeout_s) begin
            result_r    <= 32'd0;
            exception_r <= 1'b1;
        end else begin
            result_r    <= result_r;
            exception_r <= exception_r;
        end
    end

    // Stall must react in the same cycle a request shows up in IDLE, so it
    // is decoded from the state register and the live request.
    assign stall      = ((state_r == MD_IDLE) & req_s) | (state_r == MD_START) | (state_r == MD_WAIT);
    assign nop_insert = stall;

    assign md_a      = md_a_r;
    assign md_b      = md_b_r;
    assign ctrl_mult = ctrl_mult_r;
    assign ctrl_div  = ctrl_div_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign exception = exception_r;

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter MAX_CYCLES, default 40, meaning WAIT-state cycles allowed before timeout (legal range 2..63).
REQ-002 clock  input  1  master clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 is_mult  input  1  DX-stage instruction is mult.
REQ-005 is_div  input  1  DX-stage instruction is div.
REQ-006 op_a  input  32  DX-stage rs operand.
REQ-007 op_b  input  32  DX-stage rt operand.
REQ-008 md_a  output  32  held operand A to the multdiv unit.
REQ-009 md_b  output  32  held operand B to the multdiv unit.
REQ-010 ctrl_mult  output  1  one-cycle start pulse for multiply.
REQ-011 ctrl_div  output  1  one-cycle start pulse for divide.
REQ-012 md_result  input  32  multdiv unit result.
REQ-013 md_exception  input  1  multdiv unit exception (overflow, divide-by-zero).
REQ-014 md_ready  input  1  multdiv unit result valid.
REQ-015 stall  output  1  freeze PC, FD latch and DX latch.
REQ-016 nop_insert  output  1  load a bubble into the XM latch.
REQ-017 done  output  1  one-cycle result-valid strobe to the XM latch.
REQ-018 result  output  32  captured result, valid while done=1.
REQ-019 exception  output  1  captured exception, valid while done=1.
REQ-020 busy  output  1  high in START and WAIT.

Function
REQ-021 FSM states: IDLE, START, WAIT, DONE; encoding is 2 bits.
REQ-022 IDLE: when is_mult or is_div is high, the sequencer captures op_a/op_b into md_a/md_b and latches the op type (mult wins if both are high), then goes to START; otherwise it stays in IDLE.
REQ-023 START: ctrl_mult or ctrl_div is high for exactly this cycle, per the latched op; the cycle counter clears to 0; the next state is WAIT.
REQ-024 md_ready is ignored in START.
REQ-025 WAIT with md_ready=1: result<=md_result and exception<=md_exception are captured; the next state is DONE.
REQ-026 WAIT with md_ready=0: the counter increments; when the counter equals MAX_CYCLES-1, result<=0 and exception<=1 (timeout); the next state is DONE.
REQ-027 If md_ready=1 and the timeout fire in the same cycle, md_ready wins and the unit's values are captured.
REQ-028 DONE: done=1 for this one cycle; is_mult/is_div are ignored; the next state is IDLE.
REQ-029 The request still present in DX during DONE does not retrigger the sequencer.
REQ-030 A new request is accepted only in IDLE, at the earliest the cycle after DONE.
REQ-031 stall is combinational: stall = (IDLE & (is_mult|is_div)) | START | WAIT; stall=0 in DONE so the instruction advances.
REQ-032 nop_insert equals stall.
REQ-033 md_a/md_b hold stable from START through DONE.
REQ-034 result/exception hold until the next capture.
REQ-035 Minimum latency from request to done is 3 cycles (IDLE→START→WAIT with ready→DONE).
REQ-036 Counter width is 6 bits; the counter never wraps because the timeout forces DONE first.

Reset
REQ-037 On reset=1 at a rising edge: state<=IDLE, counter<=0, md_a/md_b/result<=0, op latch<=0, exception<=0.
REQ-038 Reset applies from any state, including mid-WAIT.
REQ-039 While in reset, ctrl_mult, ctrl_div, done and busy are 0.
REQ-040 While in reset, stall follows REQ-031 from the IDLE state.

Structure
REQ-041 The state encodings and the default MAX_CYCLES constant live in the shared processor package.
REQ-042 The 6-bit cycle counter is the one sub-module, named md_cycle_counter (sync clear, enable, terminal-count output).
REQ-043 No other sub-modules are instantiated.

Verification
REQ-044 Basic multiply: is_mult=1, op_a=7, op_b=6; md_ready=1 with md_result=42 on the 4th WAIT cycle → ctrl_mult pulses once, stall high from request through WAIT, then done=1, result=42, exception=0.
REQ-045 Divide by zero: is_div=1, op_a=9, op_b=0; md_ready=1 with md_exception=1 → done=1, exception=1.
REQ-046 Timeout: is_mult=1, md_ready never asserted → after exactly MAX_CYCLES WAIT cycles, done=1, result=0, exception=1.
REQ-047 Back-to-back: is_mult held high through DONE → no retrigger during DONE; a second request issued later starts a fresh START with new operands.
REQ-048 Mid-operation reset: reset=1 in the 3rd WAIT cycle → the next cycle is IDLE with all outputs 0, and no done strobe.
REQ-049 Simultaneous events: is_mult=is_div=1 → only ctrl_mult pulses; md_ready=1 on the timeout cycle with md_result=5 → result=5, exception=md_exception.
